// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiplier controller slice.
//   state_t      : controller FSM states (IDLE, LOAD, EVAL, SHIFT, DONE)
//   BOOTH_WIDTH  : default operand width / number of Booth iterations
//   count_bits() : width of the iteration counter for a given operand width
// Optional feature macro used by the controller: BOOTH_FAST_SHIFT_EN
// -----------------------------------------------------------------------------
package booth_pkg;

    localparam int BOOTH_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        SHIFT,
        DONE
    } state_t;

    // A one-iteration multiplier still needs a one-bit counter register.
    function automatic int count_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// -----------------------------------------------------------------------------
// booth_iter_counter
// Iteration counter for the Booth controller. Cleared when operands are
// loaded, stepped once per completed iteration, and flags the final
// iteration so the FSM knows when to leave the add/shift loop.
// Ports:
//   clk   in  : system clock, rising edge
//   rst   in  : asynchronous, active-low reset
//   clear in  : synchronous clear to zero (wins over inc)
//   inc   in  : advance count by one
//   last  out : count == WIDTH-1 (final iteration in progress)
// -----------------------------------------------------------------------------
module booth_iter_counter
    import booth_pkg::*;
#(
    parameter  int WIDTH = BOOTH_WIDTH,
    localparam int CW    = count_bits(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CW-1:0] count;

    // The controller never requests inc while last is set, so the count
    // never wraps within an operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/booth_controller.sv
// -----------------------------------------------------------------------------
// booth_controller
// Control FSM for a sequential radix-2 Booth multiplier datapath. On start it
// loads both operands and clears the accumulator, then runs WIDTH iterations
// of (optional add/subtract of M) followed by an arithmetic right shift,
// choosing the operation from the datapath's {Q0, Q(-1)} feedback.
// Ports:
//   clk, rst      in  : clock (rising edge), asynchronous active-low reset
//   start         in  : multiply request, only honoured in IDLE
//   Q0, Q1        in  : datapath feedback, LSB of Q and the extra bit Q(-1)
//   LoadA, LoadB  out : load multiplicand / multiplier registers
//   rs            out : clear accumulator and Q(-1)
//   LoadAdd, SEL  out : capture add (SEL=0) or subtract (SEL=1) result
//   Shift         out : arithmetic right shift of {acc, Q, Q(-1)}
//   busy          out : high from LOAD through DONE
//   done          out : one-cycle pulse when the product is valid
// Optional feature: define BOOTH_FAST_SHIFT_EN to shift directly in EVAL when
// no add is needed, skipping the SHIFT state (latency 2+WIDTH .. 2+2*WIDTH).
// -----------------------------------------------------------------------------
module booth_controller
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic Q0,
    input  logic Q1,
    output logic LoadA,
    output logic LoadB,
    output logic rs,
    output logic LoadAdd,
    output logic SEL,
    output logic Shift,
    output logic busy,
    output logic done
);

    state_t state;
    state_t next_state;
    logic   cnt_clear;
    logic   cnt_inc;
    logic   cnt_last;

    booth_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are decoded from state alone, except the add/subtract choice
    // in EVAL which follows the Booth pair {Q0, Q(-1)}.
    always_comb begin
        next_state = state;
        LoadA      = 1'b0;
        LoadB      = 1'b0;
        rs         = 1'b0;
        LoadAdd    = 1'b0;
        SEL        = 1'b0;
        Shift      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                end
            end

            LOAD: begin
                LoadA      = 1'b1;
                LoadB      = 1'b1;
                rs         = 1'b1;
                busy       = 1'b1;
                cnt_clear  = 1'b1;
                next_state = EVAL;
            end

            EVAL: begin
                busy       = 1'b1;
                next_state = SHIFT;
                // Pair 10 starts a run of ones (subtract M), pair 01 ends one
                // (add M); 00 and 11 need no arithmetic.
                if (Q0 && !Q1) begin
                    LoadAdd = 1'b1;
                    SEL     = 1'b1;
                end else if (!Q0 && Q1) begin
                    LoadAdd = 1'b1;
                end
`ifdef BOOTH_FAST_SHIFT_EN
                // No add this iteration, so the shift can happen right away
                // and the iteration completes here instead of in SHIFT.
                if (Q0 == Q1) begin
                    Shift = 1'b1;
                    if (cnt_last) begin
                        next_state = DONE;
                    end else begin
                        cnt_inc    = 1'b1;
                        next_state = EVAL;
                    end
                end
`endif
            end

            SHIFT: begin
                busy  = 1'b1;
                Shift = 1'b1;
                if (cnt_last) begin
                    next_state = DONE;
                end else begin
                    cnt_inc    = 1'b1;
                    next_state = EVAL;
                end
            end

            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/booth_controller.md
Name: booth_controller

Overview:
Control FSM directly upstream of the sequential Booth multiplier datapath. It accepts a start request and sequences LoadA/LoadB/rs, then runs WIDTH add/subtract and shift iterations. Each iteration decides from the datapath's Q0/Q1 feedback. It reports busy and a one-cycle done pulse when the datapath product is valid.

Parameters:
WIDTH, 4, operand width of the datapath; number of Booth iterations.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE
Q0  input  1  LSB of multiplier/low product register (datapath feedback)
Q1  input  1  Booth extra bit Q(-1) (datapath feedback)
LoadA  output  1  load multiplicand A into M register
LoadB  output  1  load multiplier B into low register
rs  output  1  synchronous clear of accumulator and Q(-1)
LoadAdd  output  1  capture add/sub result into accumulator
SEL  output  1  0 = add M, 1 = subtract M
Shift  output  1  arithmetic right shift of {acc, Q, Q(-1)}
busy  output  1  high from LOAD through DONE inclusive
done  output  1  one-cycle pulse; product valid from this cycle until next LOAD

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, iteration count=0, all outputs 0.
- All outputs are Moore, decoded from state, except LoadAdd/SEL in EVAL, which also depend on Q0/Q1.
- IDLE: outputs 0. start=1 -> LOAD.
- LOAD (1 cycle): LoadA=1, LoadB=1, rs=1, count<=0 -> EVAL.
- EVAL (1 cycle): {Q0,Q1}=10 -> LoadAdd=1, SEL=1. {Q0,Q1}=01 -> LoadAdd=1, SEL=0. 00 or 11 -> LoadAdd=0, SEL=0. Always -> SHIFT.
- SHIFT (1 cycle): Shift=1. If count==WIDTH-1 -> DONE, else count<=count+1 and -> EVAL.
- DONE (1 cycle): done=1 -> IDLE.
- Latency: start sampled at edge k puts LOAD at k+1, and done is high in cycle k+2+2*WIDTH (k+10 for WIDTH=4).
- start while busy, including during DONE: ignored, not queued.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE.
- The counter is $clog2(WIDTH) bits wide and never wraps during an operation.
- Reset mid-operation: immediate return to IDLE with no done pulse. Datapath contents are undefined until the next LOAD.
- LoadAdd and Shift are never asserted in the same cycle.

Optional Feature:
BOOTH_FAST_SHIFT_EN
- Defined: in EVAL, when Q0==Q1, no add is needed, so the FSM asserts Shift=1 in EVAL itself and applies the SHIFT-state count/exit rule directly, skipping SHIFT. Latency varies from 2+WIDTH to 2+2*WIDTH cycles.
- Undefined: fixed latency as described in Behaviour.

Decomposition:
- Package booth_pkg: state enum (IDLE, LOAD, EVAL, SHIFT, DONE) and BOOTH_WIDTH default constant (4).
- Sub-module booth_iter_counter: clear, increment and terminal-count flag (count==WIDTH-1). The FSM stays in booth_controller.

Test Plan:
- Reset: assert rst=0 mid-SHIFT -> outputs 0 the same cycle; after release, state IDLE and no done pulse.
- Sequence check, bench forcing {Q0,Q1}=00 every EVAL: start at cycle 0 -> LoadA/LoadB/rs at cycle 1, four Shift pulses at cycles 3/5/7/9, done at cycle 10, no LoadAdd.
- Decode: forcing {Q0,Q1}=10, 01, 11 in successive EVALs -> (LoadAdd,SEL) = (1,1), (1,0), (0,0).
- Integration with the multiplier datapath: A=3, B=2 -> prod=8'h06 at done. A=4'b1101 (-3), B=5 -> prod=8'hF1 (-15).
- Handshake: start pulsed during busy and in DONE -> ignored. start held high -> back-to-back operations with exactly one IDLE cycle between done and LOAD.
- With BOOTH_FAST_SHIFT_EN: B=0, so every pair is 00 -> done 6 cycles after start (2+WIDTH).
